// File: rtl/uart_tl_host_pkg.sv
// Shared constants and types for the TL-UL host sequencer.
package uart_tl_host_pkg;

    // A-channel opcodes
    localparam logic [2:0] OpPutFull = 3'd0;
    localparam logic [2:0] OpGet     = 3'd4;
    // D-channel opcodes
    localparam logic [2:0] OpAck     = 3'd0;
    localparam logic [2:0] OpAckData = 3'd1;

    localparam logic [1:0] SizeWord  = 2'd2;

    // Sources are always < MaxOutst (at most 16), so 4 bits cover every legal source.
    localparam int TrkSrcW = 4;

    // One entry per in-flight request, kept in issue order.
    typedef struct packed {
        logic [TrkSrcW-1:0] source;
        logic               write;
    } track_entry_t;

    // Response register contents (valid is held separately).
    typedef struct packed {
        logic [31:0] rdata;
        logic        write;
        logic        error;
        logic        timeout;
    } rsp_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HUNG = 1'b1
    } fsm_t;

endpackage

// File: rtl/uart_tl_host_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
module uart_tl_host_fifo #(
    parameter int Depth = 4,
    parameter int Width = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [Width-1:0]             wdata,
    input  logic                         pop,
    input  logic                         flush,
    output logic [Width-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr, rptr;
    logic             push_ok, pop_ok;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage array; no reset needed, reads are qualified by empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    // Pointer and occupancy update; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= (wptr == PtrW'(Depth - 1)) ? '0 : wptr + PtrW'(1);
            if (pop_ok)  rptr <= (rptr == PtrW'(Depth - 1)) ? '0 : rptr + PtrW'(1);
            if (push_ok && !pop_ok)      count <= count + CntW'(1);
            else if (pop_ok && !push_ok) count <= count - CntW'(1);
        end
    end

endmodule

// File: rtl/uart_tl_host_seq.sv
// TL-UL host sequencer: word commands in, PutFullData/Get out, in-order responses back.
module uart_tl_host_seq
    import uart_tl_host_pkg::*;
#(
    parameter int MaxOutst      = 4,
    parameter int SrcW          = 8,
    parameter int TimeoutCycles = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [31:0]                   cmd_addr,
    input  logic [31:0]                   cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_write,
    output logic                          rsp_error,
    output logic                          rsp_timeout,
    output logic                          tl_a_valid,
    output logic [2:0]                    tl_a_opcode,
    output logic [1:0]                    tl_a_size,
    output logic [3:0]                    tl_a_mask,
    output logic [31:0]                   tl_a_address,
    output logic [31:0]                   tl_a_data,
    output logic [SrcW-1:0]               tl_a_source,
    output logic [2:0]                    tl_a_param,
    output logic                          tl_d_ready,
    input  logic                          tl_a_ready,
    input  logic                          tl_d_valid,
    input  logic [2:0]                    tl_d_opcode,
    input  logic [31:0]                   tl_d_data,
    input  logic [SrcW-1:0]               tl_d_source,
    input  logic                          tl_d_error,
    output logic [$clog2(MaxOutst+1)-1:0] outst_cnt,
    output logic                          hung
);

    localparam int IdxW = $clog2(MaxOutst);
    localparam int TmoW = $clog2(TimeoutCycles);

    fsm_t              fsm_q, fsm_d;
    logic              rst_done;
    logic [IdxW-1:0]   src_cnt;
    logic [TmoW-1:0]   tmo_cnt;
    rsp_t              rsp_q;

    track_entry_t      push_entry, head;
    logic              fifo_full, fifo_empty;
    logic              run, rsp_free, cmd_acc, d_acc, tmo_fire, pop;

    assign run        = (fsm_q == RUN);
    assign rsp_free   = !rsp_valid || rsp_ready;
    assign cmd_acc    = cmd_valid && cmd_ready;
    // Written without tl_d_ready to keep the comb graph acyclic; same condition.
    assign d_acc      = run && rsp_free && !fifo_empty && tl_d_valid;
    // A D beat in the expiry cycle still wins over the timeout.
    assign tmo_fire   = run && rsp_free && !fifo_empty && !tl_d_valid &&
                        (tmo_cnt == TmoW'(TimeoutCycles - 1));
    assign pop        = d_acc || tmo_fire;

    assign push_entry = '{source: TrkSrcW'(src_cnt), write: cmd_write};

    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_write   = rsp_q.write;
    assign rsp_error   = rsp_q.error;
    assign rsp_timeout = rsp_q.timeout;

    uart_tl_host_fifo #(
        .Depth (MaxOutst),
        .Width ($bits(track_entry_t))
    ) u_track (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_acc),
        .wdata (push_entry),
        .pop   (pop),
        .flush (tmo_fire),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outst_cnt)
    );

    // Holds cmd_ready low while reset is asserted and for the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_done <= 1'b0;
        else     rst_done <= 1'b1;
    end

    // State register; HUNG is only left through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= RUN;
        else     fsm_q <= fsm_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        fsm_d      = fsm_q;
        cmd_ready  = 1'b0;
        tl_d_ready = 1'b0;
        hung       = 1'b0;
        case (fsm_q)
            RUN: begin
                cmd_ready  = rst_done && !fifo_full && (!tl_a_valid || tl_a_ready);
                tl_d_ready = rsp_free && !fifo_empty;
                if (tmo_fire) fsm_d = HUNG;
            end
            HUNG:    hung  = 1'b1;
            default: fsm_d = RUN;
        endcase
    end

    // A-channel output register; fields only change on a new accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_a_valid   <= 1'b0;
            tl_a_opcode  <= '0;
            tl_a_size    <= '0;
            tl_a_mask    <= '0;
            tl_a_address <= '0;
            tl_a_data    <= '0;
            tl_a_source  <= '0;
            tl_a_param   <= '0;
            src_cnt      <= '0;
        end else if (cmd_acc) begin
            tl_a_valid   <= 1'b1;
            tl_a_opcode  <= cmd_write ? OpPutFull : OpGet;
            tl_a_size    <= SizeWord;
            tl_a_mask    <= 4'hF;
            tl_a_address <= cmd_addr & ~32'h3;
            tl_a_data    <= cmd_write ? cmd_wdata : 32'h0;
            tl_a_source  <= SrcW'(src_cnt);
            tl_a_param   <= 3'd0;
            src_cnt      <= src_cnt + IdxW'(1);
        end else if (tl_a_ready) begin
            tl_a_valid   <= 1'b0;
        end
    end

    // Waiting-time counter for the oldest request; restarts on every pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            tmo_cnt <= '0;
        else if (pop || fifo_empty)         tmo_cnt <= '0;
        else if (tmo_cnt != TmoW'(TimeoutCycles - 1))
                                            tmo_cnt <= tmo_cnt + TmoW'(1);
    end

    // Response register: loads from a D beat or a synthesized timeout, holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (d_acc) begin
            rsp_valid     <= 1'b1;
            rsp_q.rdata   <= head.write ? 32'h0 : tl_d_data;
            rsp_q.write   <= head.write;
            rsp_q.error   <= tl_d_error ||
                             (tl_d_source != SrcW'(head.source)) ||
                             (tl_d_opcode != (head.write ? OpAck : OpAckData));
            rsp_q.timeout <= 1'b0;
        end else if (tmo_fire) begin
            rsp_valid     <= 1'b1;
            rsp_q.rdata   <= 32'h0;
            rsp_q.write   <= head.write;
            rsp_q.error   <= 1'b1;
            rsp_q.timeout <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tl_host_seq.sv
// Directed bench for uart_tl_host_seq (MaxOutst=4, SrcW=8, TimeoutCycles=16).
module tb_uart_tl_host_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_write, rsp_error, rsp_timeout;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        tl_a_valid, tl_d_ready;
    logic [2:0]  tl_a_opcode, tl_a_param;
    logic [1:0]  tl_a_size;
    logic [3:0]  tl_a_mask;
    logic [31:0] tl_a_address, tl_a_data;
    logic [7:0]  tl_a_source;
    logic        tl_a_ready = 1'b1;
    logic        tl_d_valid = 1'b0, tl_d_error = 1'b0;
    logic [2:0]  tl_d_opcode = '0;
    logic [31:0] tl_d_data = '0;
    logic [7:0]  tl_d_source = '0;
    logic [2:0]  outst_cnt;
    logic        hung;

    int checks   = 0;
    int failures = 0;

    uart_tl_host_seq #(.MaxOutst(4), .SrcW(8), .TimeoutCycles(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .tl_a_valid(tl_a_valid), .tl_a_opcode(tl_a_opcode), .tl_a_size(tl_a_size),
        .tl_a_mask(tl_a_mask), .tl_a_address(tl_a_address), .tl_a_data(tl_a_data),
        .tl_a_source(tl_a_source), .tl_a_param(tl_a_param), .tl_d_ready(tl_d_ready),
        .tl_a_ready(tl_a_ready), .tl_d_valid(tl_d_valid), .tl_d_opcode(tl_d_opcode),
        .tl_d_data(tl_d_data), .tl_d_source(tl_d_source), .tl_d_error(tl_d_error),
        .outst_cnt(outst_cnt), .hung(hung)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bit done = 1'b0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        for (int i = 0; i < 50 && !done; i++) begin
            #1; done = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL cmd_accept_bound got=no_accept exp=accept"); end
    endtask

    // Present one D beat and hold it until accepted (bounded).
    task automatic d_beat(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data, input logic err);
        bit done = 1'b0;
        tl_d_valid = 1'b1; tl_d_opcode = op; tl_d_source = src; tl_d_data = data; tl_d_error = err;
        for (int i = 0; i < 50 && !done; i++) begin
            #1; done = tl_d_ready;
            tick();
        end
        tl_d_valid = 1'b0; tl_d_error = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL d_accept_bound got=no_accept exp=accept"); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1;
        #12;
        checks += 7;
        if (tl_a_valid !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%0h exp=0", tl_a_valid); end
        if (rsp_valid  !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%0h exp=0", rsp_valid); end
        if (cmd_ready  !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%0h exp=0", cmd_ready); end
        if (tl_d_ready !== 1'b0) begin failures++; $display("FAIL rst_d_ready got=%0h exp=0", tl_d_ready); end
        if (outst_cnt  !== 3'd0) begin failures++; $display("FAIL rst_outst got=%0d exp=0", outst_cnt); end
        if (hung       !== 1'b0) begin failures++; $display("FAIL rst_hung got=%0h exp=0", hung); end
        if (tl_a_address !== 32'h0) begin failures++; $display("FAIL rst_a_addr got=%0h exp=0", tl_a_address); end
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick(); tick();
    endtask

    task automatic test_write_read();
        send_cmd(1'b1, 32'h10, 32'hA5);
        checks += 9;
        if (tl_a_valid   !== 1'b1)   begin failures++; $display("FAIL wr_a_valid got=%0h exp=1", tl_a_valid); end
        if (tl_a_opcode  !== 3'd0)   begin failures++; $display("FAIL wr_a_opcode got=%0h exp=0", tl_a_opcode); end
        if (tl_a_source  !== 8'd0)   begin failures++; $display("FAIL wr_a_source got=%0h exp=0", tl_a_source); end
        if (tl_a_address !== 32'h10) begin failures++; $display("FAIL wr_a_addr got=%0h exp=10", tl_a_address); end
        if (tl_a_data    !== 32'hA5) begin failures++; $display("FAIL wr_a_data got=%0h exp=a5", tl_a_data); end
        if (tl_a_mask    !== 4'hF)   begin failures++; $display("FAIL wr_a_mask got=%0h exp=f", tl_a_mask); end
        if (tl_a_size    !== 2'd2)   begin failures++; $display("FAIL wr_a_size got=%0h exp=2", tl_a_size); end
        if (tl_a_param   !== 3'd0)   begin failures++; $display("FAIL wr_a_param got=%0h exp=0", tl_a_param); end
        if (outst_cnt    !== 3'd1)   begin failures++; $display("FAIL wr_outst got=%0d exp=1", outst_cnt); end
        send_cmd(1'b0, 32'h10, 32'h1234);
        checks += 4;
        if (tl_a_opcode !== 3'd4)  begin failures++; $display("FAIL rd_a_opcode got=%0h exp=4", tl_a_opcode); end
        if (tl_a_source !== 8'd1)  begin failures++; $display("FAIL rd_a_source got=%0h exp=1", tl_a_source); end
        if (tl_a_data   !== 32'h0) begin failures++; $display("FAIL rd_a_data got=%0h exp=0", tl_a_data); end
        if (outst_cnt   !== 3'd2)  begin failures++; $display("FAIL rd_outst got=%0d exp=2", outst_cnt); end
        d_beat(3'd0, 8'd0, 32'h1111, 1'b0);
        checks += 5;
        if (rsp_valid   !== 1'b1)  begin failures++; $display("FAIL wr_rsp_valid got=%0h exp=1", rsp_valid); end
        if (rsp_write   !== 1'b1)  begin failures++; $display("FAIL wr_rsp_write got=%0h exp=1", rsp_write); end
        if (rsp_error   !== 1'b0)  begin failures++; $display("FAIL wr_rsp_error got=%0h exp=0", rsp_error); end
        if (rsp_rdata   !== 32'h0) begin failures++; $display("FAIL wr_rsp_rdata got=%0h exp=0", rsp_rdata); end
        if (rsp_timeout !== 1'b0)  begin failures++; $display("FAIL wr_rsp_timeout got=%0h exp=0", rsp_timeout); end
        d_beat(3'd1, 8'd1, 32'hDEADBEEF, 1'b0);
        checks += 4;
        if (rsp_write !== 1'b0)         begin failures++; $display("FAIL rd_rsp_write got=%0h exp=0", rsp_write); end
        if (rsp_error !== 1'b0)         begin failures++; $display("FAIL rd_rsp_error got=%0h exp=0", rsp_error); end
        if (rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rsp_rdata got=%0h exp=deadbeef", rsp_rdata); end
        if (outst_cnt !== 3'd0)         begin failures++; $display("FAIL rd_outst_drain got=%0d exp=0", outst_cnt); end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_consumed got=%0h exp=0", rsp_valid); end
    endtask

    task automatic test_align();
        send_cmd(1'b0, 32'h13, 32'hFFFF);
        checks += 4;
        if (tl_a_address !== 32'h10) begin failures++; $display("FAIL al_a_addr got=%0h exp=10", tl_a_address); end
        if (tl_a_mask    !== 4'hF)   begin failures++; $display("FAIL al_a_mask got=%0h exp=f", tl_a_mask); end
        if (tl_a_size    !== 2'd2)   begin failures++; $display("FAIL al_a_size got=%0h exp=2", tl_a_size); end
        if (tl_a_source  !== 8'd2)   begin failures++; $display("FAIL al_a_source got=%0h exp=2", tl_a_source); end
        d_beat(3'd1, 8'd2, 32'h1234, 1'b0);
        checks += 2;
        if (rsp_rdata !== 32'h1234) begin failures++; $display("FAIL al_rsp_rdata got=%0h exp=1234", rsp_rdata); end
        if (rsp_error !== 1'b0)     begin failures++; $display("FAIL al_rsp_error got=%0h exp=0", rsp_error); end
    endtask

    task automatic test_backpressure();
        tl_a_ready = 1'b0;
        send_cmd(1'b1, 32'h20, 32'h55);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24; cmd_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks += 5;
            if (tl_a_valid   !== 1'b1)   begin failures++; $display("FAIL bp_a_valid[%0d] got=%0h exp=1", i, tl_a_valid); end
            if (tl_a_address !== 32'h20) begin failures++; $display("FAIL bp_a_addr[%0d] got=%0h exp=20", i, tl_a_address); end
            if (tl_a_data    !== 32'h55) begin failures++; $display("FAIL bp_a_data[%0d] got=%0h exp=55", i, tl_a_data); end
            if (tl_a_source  !== 8'd3)   begin failures++; $display("FAIL bp_a_source[%0d] got=%0h exp=3", i, tl_a_source); end
            if (cmd_ready    !== 1'b0)   begin failures++; $display("FAIL bp_cmd_ready[%0d] got=%0h exp=0", i, cmd_ready); end
            tick();
        end
        tl_a_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0h exp=1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks += 4;
        if (tl_a_opcode  !== 3'd4)   begin failures++; $display("FAIL b2b_a_opcode got=%0h exp=4", tl_a_opcode); end
        if (tl_a_address !== 32'h24) begin failures++; $display("FAIL b2b_a_addr got=%0h exp=24", tl_a_address); end
        if (tl_a_source  !== 8'd0)   begin failures++; $display("FAIL b2b_a_source got=%0h exp=0", tl_a_source); end
        if (outst_cnt    !== 3'd2)   begin failures++; $display("FAIL b2b_outst got=%0d exp=2", outst_cnt); end
        rsp_ready = 1'b0;
        d_beat(3'd0, 8'd3, 32'h0, 1'b0);
        tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 8'd0; tl_d_data = 32'hCAFE0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks += 3;
            if (tl_d_ready !== 1'b0) begin failures++; $display("FAIL bp_d_ready[%0d] got=%0h exp=0", i, tl_d_ready); end
            if (rsp_valid  !== 1'b1) begin failures++; $display("FAIL bp_rsp_hold[%0d] got=%0h exp=1", i, rsp_valid); end
            if (rsp_write  !== 1'b1) begin failures++; $display("FAIL bp_rsp_write[%0d] got=%0h exp=1", i, rsp_write); end
            tick();
        end
        rsp_ready = 1'b1;
        d_beat(3'd1, 8'd0, 32'hCAFE0001, 1'b0);
        checks += 4;
        if (rsp_valid !== 1'b1)         begin failures++; $display("FAIL bp_rsp2_valid got=%0h exp=1", rsp_valid); end
        if (rsp_write !== 1'b0)         begin failures++; $display("FAIL bp_rsp2_write got=%0h exp=0", rsp_write); end
        if (rsp_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL bp_rsp2_rdata got=%0h exp=cafe0001", rsp_rdata); end
        if (outst_cnt !== 3'd0)         begin failures++; $display("FAIL bp_outst got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_mismatch();
        send_cmd(1'b0, 32'h40, 32'h0);
        d_beat(3'd1, 8'd3, 32'h77, 1'b0);
        checks += 2;
        if (rsp_error   !== 1'b1) begin failures++; $display("FAIL mm_src_error got=%0h exp=1", rsp_error); end
        if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL mm_src_timeout got=%0h exp=0", rsp_timeout); end
        send_cmd(1'b0, 32'h44, 32'h0);
        d_beat(3'd0, 8'd2, 32'h88, 1'b0);
        checks++;
        if (rsp_error !== 1'b1) begin failures++; $display("FAIL mm_op_error got=%0h exp=1", rsp_error); end
        send_cmd(1'b0, 32'h48, 32'h0);
        d_beat(3'd1, 8'd3, 32'h99, 1'b1);
        checks += 2;
        if (rsp_error !== 1'b1)    begin failures++; $display("FAIL mm_derr_error got=%0h exp=1", rsp_error); end
        if (rsp_rdata !== 32'h99)  begin failures++; $display("FAIL mm_derr_rdata got=%0h exp=99", rsp_rdata); end
    endtask

    task automatic test_outstanding();
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b0, 32'h100 + 32'(4 * i), 32'h0);
            checks += 2;
            if (tl_a_source !== 8'(i))     begin failures++; $display("FAIL os_src[%0d] got=%0h exp=%0h", i, tl_a_source, i); end
            if (outst_cnt   !== 3'(i + 1)) begin failures++; $display("FAIL os_cnt[%0d] got=%0d exp=%0d", i, outst_cnt, i + 1); end
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h110;
        #1;
        checks += 2;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL os_full_ready got=%0h exp=0", cmd_ready); end
        if (outst_cnt !== 3'd4) begin failures++; $display("FAIL os_full_cnt got=%0d exp=4", outst_cnt); end
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL os_full_ready2 got=%0h exp=0", cmd_ready); end
        d_beat(3'd1, 8'd0, 32'hA0, 1'b0);
        checks += 2;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL os_pop_ready got=%0h exp=1", cmd_ready); end
        if (outst_cnt !== 3'd3) begin failures++; $display("FAIL os_pop_cnt got=%0d exp=3", outst_cnt); end
        tick();
        cmd_valid = 1'b0;
        checks += 3;
        if (tl_a_source  !== 8'd0)    begin failures++; $display("FAIL os_5th_src got=%0h exp=0", tl_a_source); end
        if (tl_a_address !== 32'h110) begin failures++; $display("FAIL os_5th_addr got=%0h exp=110", tl_a_address); end
        if (outst_cnt    !== 3'd4)    begin failures++; $display("FAIL os_5th_cnt got=%0d exp=4", outst_cnt); end
        for (int i = 1; i <= 4; i++) begin
            d_beat(3'd1, 8'(i % 4), 32'hB0 + 32'(i), 1'b0);
            checks += 2;
            if (rsp_error !== 1'b0)              begin failures++; $display("FAIL os_drain_err[%0d] got=%0h exp=0", i, rsp_error); end
            if (rsp_rdata !== 32'hB0 + 32'(i))   begin failures++; $display("FAIL os_drain_rdata[%0d] got=%0h exp=%0h", i, rsp_rdata, 32'hB0 + 32'(i)); end
        end
        checks++;
        if (outst_cnt !== 3'd0) begin failures++; $display("FAIL os_drain_cnt got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_timeout();
        int n = 0;
        send_cmd(1'b0, 32'h80, 32'h0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h84;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (i == 1) begin
                cmd_valid = 1'b0;
                checks++;
                if (outst_cnt !== 3'd2) begin failures++; $display("FAIL to_cnt2 got=%0d exp=2", outst_cnt); end
            end
            if (rsp_valid) n = i;
        end
        checks += 8;
        if (n != 16)              begin failures++; $display("FAIL to_latency got=%0d exp=16", n); end
        if (rsp_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%0h exp=1", rsp_timeout); end
        if (rsp_error   !== 1'b1) begin failures++; $display("FAIL to_error got=%0h exp=1", rsp_error); end
        if (rsp_rdata   !== 32'h0) begin failures++; $display("FAIL to_rdata got=%0h exp=0", rsp_rdata); end
        if (rsp_write   !== 1'b0) begin failures++; $display("FAIL to_write got=%0h exp=0", rsp_write); end
        if (hung        !== 1'b1) begin failures++; $display("FAIL to_hung got=%0h exp=1", hung); end
        if (outst_cnt   !== 3'd0) begin failures++; $display("FAIL to_discard got=%0d exp=0", outst_cnt); end
        if (tl_a_valid  !== 1'b0) begin failures++; $display("FAIL to_a_valid got=%0h exp=0", tl_a_valid); end
        cmd_valid = 1'b1; cmd_addr = 32'h88;
        tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 8'd2;
        #1;
        checks += 2;
        if (cmd_ready  !== 1'b0) begin failures++; $display("FAIL to_cmd_ready got=%0h exp=0", cmd_ready); end
        if (tl_d_ready !== 1'b0) begin failures++; $display("FAIL to_d_ready got=%0h exp=0", tl_d_ready); end
        tick(); tick();
        checks += 3;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_no_extra_rsp got=%0h exp=0", rsp_valid); end
        if (hung      !== 1'b1) begin failures++; $display("FAIL to_hung_sticky got=%0h exp=1", hung); end
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL to_cmd_ready2 got=%0h exp=0", cmd_ready); end
        cmd_valid = 1'b0; tl_d_valid = 1'b0;
    endtask

    task automatic test_reset_recover();
        rst = 1'b1;
        #1;
        checks += 2;
        if (hung      !== 1'b0) begin failures++; $display("FAIL rr_hung got=%0h exp=0", hung); end
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rr_cmd_ready got=%0h exp=0", cmd_ready); end
        tick();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rr_ready_after got=%0h exp=1", cmd_ready); end
        send_cmd(1'b1, 32'h200, 32'h5A);
        checks += 2;
        if (tl_a_source !== 8'd0) begin failures++; $display("FAIL rr_src_restart got=%0h exp=0", tl_a_source); end
        if (tl_a_opcode !== 3'd0) begin failures++; $display("FAIL rr_opcode got=%0h exp=0", tl_a_opcode); end
        d_beat(3'd0, 8'd0, 32'h0, 1'b0);
        checks += 2;
        if (rsp_error !== 1'b0) begin failures++; $display("FAIL rr_rsp_error got=%0h exp=0", rsp_error); end
        if (rsp_write !== 1'b1) begin failures++; $display("FAIL rr_rsp_write got=%0h exp=1", rsp_write); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_align();
        test_backpressure();
        test_mismatch();
        test_outstanding();
        test_timeout();
        test_reset_recover();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
